// File: rtl/reorder_buffer_pkg.sv
// Shared widths, opcode classes and tag helpers for the reorder buffer and
// the reservation station that consumes its tags.
package reorder_buffer_pkg;

    localparam int ROB_SIZE   = 8;
    localparam int ID_WIDTH   = 4;
    localparam int VAL_WIDTH  = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int OP_WIDTH   = 6;
    localparam int REG_WIDTH  = 5;
    localparam int IDX_WIDTH  = $clog2(ROB_SIZE);
    localparam int CNT_WIDTH  = IDX_WIDTH + 1;

    // Instruction classes, shared with the reservation station.
    localparam logic [OP_WIDTH-1:0] OP_LUI    = 6'd1;
    localparam logic [OP_WIDTH-1:0] OP_AUIPC  = 6'd2;
    localparam logic [OP_WIDTH-1:0] OP_JAL    = 6'd3;
    localparam logic [OP_WIDTH-1:0] OP_JALR   = 6'd4;
    localparam logic [OP_WIDTH-1:0] OP_BRANCH = 6'd5;
    localparam logic [OP_WIDTH-1:0] OP_I_TYPE = 6'd6;
    localparam logic [OP_WIDTH-1:0] OP_R_TYPE = 6'd7;

    // Jumps write the link value rather than the computed target.
    function automatic logic is_link_op(input logic [OP_WIDTH-1:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Classes whose committed value is a next PC that may disagree with the prediction.
    function automatic logic is_redirect_op(input logic [OP_WIDTH-1:0] op);
        return (op == OP_BRANCH) || (op == OP_JALR);
    endfunction

    // Tag 0 means "no dependency"; tags above ROB_SIZE name no entry.
    function automatic logic tag_is_entry(input logic [ID_WIDTH-1:0] tag);
        return (tag != {ID_WIDTH{1'b0}}) && (tag <= ID_WIDTH'(ROB_SIZE));
    endfunction

    function automatic logic [IDX_WIDTH-1:0] tag_to_idx(input logic [ID_WIDTH-1:0] tag);
        return IDX_WIDTH'(tag - ID_WIDTH'(1));
    endfunction

    function automatic logic [ID_WIDTH-1:0] idx_to_tag(input logic [IDX_WIDTH-1:0] idx);
        return ID_WIDTH'(idx) + ID_WIDTH'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer_lookup.sv
// Combinational operand lookup: tag -> (ready, value), with same-cycle CDB bypass.
module rob_lookup
    import reorder_buffer_pkg::*;
(
    input  logic [ID_WIDTH-1:0]                query_tag_i,
    input  logic                               cdb_valid_i,
    input  logic [ID_WIDTH-1:0]                cdb_tag_i,
    input  logic [VAL_WIDTH-1:0]               cdb_val_i,
    input  logic [ROB_SIZE-1:0]                entry_ready_i,
    input  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0] entry_res_i,
    output logic                               ready_o,
    output logic [VAL_WIDTH-1:0]               res_o
);

    logic [IDX_WIDTH-1:0] idx_s;

    assign idx_s = tag_to_idx(query_tag_i);

    // Priority: no dependency, then a result on the bus this cycle, then the stored entry.
    always_comb begin
        ready_o = 1'b0;
        res_o   = {VAL_WIDTH{1'b0}};
        if (query_tag_i == {ID_WIDTH{1'b0}}) begin
            ready_o = 1'b1;
            res_o   = {VAL_WIDTH{1'b0}};
        end else if (cdb_valid_i && (cdb_tag_i == query_tag_i)) begin
            ready_o = 1'b1;
            res_o   = cdb_val_i;
        end else if (tag_is_entry(query_tag_i)) begin
            ready_o = entry_ready_i[idx_s];
            res_o   = entry_res_i[idx_s];
        end else begin
            ready_o = 1'b0;
            res_o   = {VAL_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results,
// answers operand lookups and retires in program order, flushing on mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  issue_valid,
    input  logic [OP_WIDTH-1:0]   issue_type,
    input  logic [REG_WIDTH-1:0]  issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_pred_pc,
    output logic                  rob_full,
    output logic [ID_WIDTH-1:0]   new_tag,
    input  logic [ID_WIDTH-1:0]   query_tag1,
    input  logic [ID_WIDTH-1:0]   query_tag2,
    output logic                  ready1,
    output logic                  ready2,
    output logic [VAL_WIDTH-1:0]  res1,
    output logic [VAL_WIDTH-1:0]  res2,
    input  logic                  cdb_valid,
    input  logic [ID_WIDTH-1:0]   cdb_tag,
    input  logic [VAL_WIDTH-1:0]  cdb_val,
    input  logic [VAL_WIDTH-1:0]  cdb_link,
    output logic                  commit_valid,
    output logic [REG_WIDTH-1:0]  commit_rd,
    output logic [VAL_WIDTH-1:0]  commit_val,
    output logic [ID_WIDTH-1:0]   commit_tag,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc
);

    // Control state
    logic [IDX_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [ROB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d;

    // Per-entry payload
    logic [OP_WIDTH-1:0]   type_q    [ROB_SIZE];
    logic [REG_WIDTH-1:0]  rd_q      [ROB_SIZE];
    logic [ADDR_WIDTH-1:0] pred_pc_q [ROB_SIZE];
    logic [VAL_WIDTH-1:0]  value_q   [ROB_SIZE];
    logic [VAL_WIDTH-1:0]  link_q    [ROB_SIZE];

    // Registered outputs
    logic                  commit_valid_q, commit_valid_d;
    logic [REG_WIDTH-1:0]  commit_rd_q, commit_rd_d;
    logic [VAL_WIDTH-1:0]  commit_val_q, commit_val_d;
    logic [ID_WIDTH-1:0]   commit_tag_q, commit_tag_d;
    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;

    logic                               full_s, issue_s, capture_s, commit_s, mispredict_s;
    logic [IDX_WIDTH-1:0]               cdb_idx_s;
    logic [ROB_SIZE-1:0][VAL_WIDTH-1:0] entry_res_s;

    assign full_s    = (count_q == CNT_WIDTH'(ROB_SIZE));
    assign cdb_idx_s = tag_to_idx(cdb_tag);

    // Fullness is judged before this cycle's commit, so a full buffer refills a cycle later.
    assign issue_s      = rdy_in && issue_valid && !full_s;
    assign capture_s    = rdy_in && cdb_valid && tag_is_entry(cdb_tag) && busy_q[cdb_idx_s];
    assign commit_s     = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign mispredict_s = commit_s && is_redirect_op(type_q[head_q])
                          && (ADDR_WIDTH'(value_q[head_q]) != pred_pc_q[head_q]);

    assign rob_full     = full_s;
    assign new_tag      = idx_to_tag(tail_q);
    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_val   = commit_val_q;
    assign commit_tag   = commit_tag_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

    // Architectural result of each entry: link value for jumps, computed value otherwise.
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            entry_res_s[i] = is_link_op(type_q[i]) ? link_q[i] : value_q[i];
        end
    end

    rob_lookup u_lookup1 (
        .query_tag_i   (query_tag1),
        .cdb_valid_i   (cdb_valid),
        .cdb_tag_i     (cdb_tag),
        .cdb_val_i     (cdb_val),
        .entry_ready_i (ready_q),
        .entry_res_i   (entry_res_s),
        .ready_o       (ready1),
        .res_o         (res1)
    );

    rob_lookup u_lookup2 (
        .query_tag_i   (query_tag2),
        .cdb_valid_i   (cdb_valid),
        .cdb_tag_i     (cdb_tag),
        .cdb_val_i     (cdb_val),
        .entry_ready_i (ready_q),
        .entry_res_i   (entry_res_s),
        .ready_o       (ready2),
        .res_o         (res2)
    );

    // Next pointers, occupancy and busy/ready bits; a mispredict empties the buffer.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;

        if (capture_s) begin
            ready_d[cdb_idx_s] = 1'b1;
        end else begin
            ready_d = ready_d;
        end

        if (commit_s) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + IDX_WIDTH'(1);
        end else begin
            head_d = head_q;
        end

        if (issue_s) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + IDX_WIDTH'(1);
        end else begin
            tail_d = tail_q;
        end

        case ({issue_s, commit_s})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        if (mispredict_s) begin
            busy_d  = {ROB_SIZE{1'b0}};
            ready_d = {ROB_SIZE{1'b0}};
            head_d  = {IDX_WIDTH{1'b0}};
            tail_d  = {IDX_WIDTH{1'b0}};
            count_d = {CNT_WIDTH{1'b0}};
        end else begin
            count_d = count_d;
        end
    end

    // Commit and flush outputs: pulses last one enabled edge, payloads hold between pulses.
    always_comb begin
        commit_valid_d = commit_s;
        flush_d        = mispredict_s;
        if (commit_s) begin
            commit_rd_d  = (type_q[head_q] == OP_BRANCH) ? {REG_WIDTH{1'b0}} : rd_q[head_q];
            commit_val_d = entry_res_s[head_q];
            commit_tag_d = idx_to_tag(head_q);
        end else begin
            commit_rd_d  = commit_rd_q;
            commit_val_d = commit_val_q;
            commit_tag_d = commit_tag_q;
        end
        if (mispredict_s) begin
            flush_pc_d = ADDR_WIDTH'(value_q[head_q]);
        end else begin
            flush_pc_d = flush_pc_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            head_q         <= {IDX_WIDTH{1'b0}};
            tail_q         <= {IDX_WIDTH{1'b0}};
            count_q        <= {CNT_WIDTH{1'b0}};
            busy_q         <= {ROB_SIZE{1'b0}};
            ready_q        <= {ROB_SIZE{1'b0}};
            commit_valid_q <= 1'b0;
            commit_rd_q    <= {REG_WIDTH{1'b0}};
            commit_val_q   <= {VAL_WIDTH{1'b0}};
            commit_tag_q   <= {ID_WIDTH{1'b0}};
            flush_q        <= 1'b0;
            flush_pc_q     <= {ADDR_WIDTH{1'b0}};
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_val_q   <= commit_val_d;
            commit_tag_q   <= commit_tag_d;
            flush_q        <= flush_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    // Entry payload: written at the tail on issue and at the producing entry on capture.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i]    <= {OP_WIDTH{1'b0}};
                rd_q[i]      <= {REG_WIDTH{1'b0}};
                pred_pc_q[i] <= {ADDR_WIDTH{1'b0}};
                value_q[i]   <= {VAL_WIDTH{1'b0}};
                link_q[i]    <= {VAL_WIDTH{1'b0}};
            end
        end else begin
            if (issue_s) begin
                type_q[tail_q]    <= issue_type;
                rd_q[tail_q]      <= issue_rd;
                pred_pc_q[tail_q] <= issue_pred_pc;
            end
            if (capture_s) begin
                value_q[cdb_idx_s] <= cdb_val;
                link_q[cdb_idx_s]  <= cdb_link;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a queue-based model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, issue_valid, cdb_valid;
    logic [5:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pred_pc, cdb_val, cdb_link;
    logic [3:0]  query_tag1, query_tag2, cdb_tag;
    logic        rob_full, ready1, ready2, commit_valid, flush;
    logic [3:0]  new_tag, commit_tag;
    logic [31:0] res1, res2, commit_val, flush_pc;
    logic [4:0]  commit_rd;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred_pc(issue_pred_pc), .rob_full(rob_full), .new_tag(new_tag),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .ready1(ready1), .ready2(ready2), .res1(res1), .res2(res2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_link(cdb_link),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_tag(commit_tag), .flush(flush), .flush_pc(flush_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic iv, input logic [5:0] ty, input logic [4:0] rd,
                         input logic [31:0] pred, input logic cv, input logic [3:0] ct,
                         input logic [31:0] cval, input logic [31:0] clink,
                         input logic [3:0] q1, input logic [3:0] q2);
        rdy_in = rdy; issue_valid = iv; issue_type = ty; issue_rd = rd; issue_pred_pc = pred;
        cdb_valid = cv; cdb_tag = ct; cdb_val = cval; cdb_link = clink;
        query_tag1 = q1; query_tag2 = q2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b1;
        #1;
        rst_in = 1'b0;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst, rdy, iv;      logic [5:0] ity; logic [4:0] ird; logic [31:0] ipred;
        logic cv;                logic [3:0] ctag; logic [31:0] cval, clink;
        logic [3:0] q1, q2;      logic c1, c2, er1, er2; logic [31:0] eres1, eres2;
        logic efull;             logic [3:0] entag;
        logic ecv;               logic [4:0] ecrd; logic [31:0] ecval; logic [3:0] ectag;
        logic efl;               logic [31:0] eflpc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t N(input logic [3:0] ntag, input logic full);
        vec_t v;
        v = '{default: '0};
        v.rdy = 1'b1; v.entag = ntag; v.efull = full;
        return v;
    endfunction
    function automatic vec_t I(input logic [5:0] ty, input logic [4:0] rd, input logic [31:0] pred,
                               input logic [3:0] ntag, input logic full);
        vec_t v;
        v = N(ntag, full);
        v.iv = 1'b1; v.ity = ty; v.ird = rd; v.ipred = pred;
        return v;
    endfunction
    function automatic vec_t wc(input vec_t vi, input logic [3:0] t, input logic [31:0] val, input logic [31:0] lk);
        vec_t v;
        v = vi; v.cv = 1'b1; v.ctag = t; v.cval = val; v.clink = lk;
        return v;
    endfunction
    function automatic vec_t wcm(input vec_t vi, input logic [4:0] rd, input logic [31:0] val, input logic [3:0] t);
        vec_t v;
        v = vi; v.ecv = 1'b1; v.ecrd = rd; v.ecval = val; v.ectag = t;
        return v;
    endfunction
    function automatic vec_t wfl(input vec_t vi, input logic [31:0] pc);
        vec_t v;
        v = vi; v.efl = 1'b1; v.eflpc = pc;
        return v;
    endfunction
    function automatic vec_t wq1(input vec_t vi, input logic [3:0] t, input logic r, input logic [31:0] res);
        vec_t v;
        v = vi; v.q1 = t; v.c1 = 1'b1; v.er1 = r; v.eres1 = res;
        return v;
    endfunction
    function automatic vec_t wq2(input vec_t vi, input logic [3:0] t, input logic r, input logic [31:0] res);
        vec_t v;
        v = vi; v.q2 = t; v.c2 = 1'b1; v.er2 = r; v.eres2 = res;
        return v;
    endfunction
    function automatic vec_t wr(input vec_t vi);
        vec_t v;
        v = vi; v.rst = 1'b1;
        return v;
    endfunction

    task automatic build_table();
        // In-order commit of out-of-order results
        tbl.push_back(wr(I(OP_R_TYPE, 5'd5, 32'h0, 4'd1, 1'b0)));
        tbl.push_back(I(OP_R_TYPE, 5'd6, 32'h0, 4'd2, 1'b0));
        tbl.push_back(I(OP_R_TYPE, 5'd7, 32'h0, 4'd3, 1'b0));
        tbl.push_back(wq2(wq1(wc(N(4'd4, 1'b0), 4'd2, 32'h22, 32'h0), 4'd2, 1'b1, 32'h22), 4'd0, 1'b1, 32'h0));
        tbl.push_back(wq1(wc(N(4'd4, 1'b0), 4'd1, 32'h11, 32'h0), 4'd2, 1'b1, 32'h22));
        tbl.push_back(wcm(N(4'd4, 1'b0), 5'd5, 32'h11, 4'd1));
        tbl.push_back(wcm(N(4'd4, 1'b0), 5'd6, 32'h22, 4'd2));
        tbl.push_back(wc(N(4'd4, 1'b0), 4'd3, 32'h33, 32'h0));
        tbl.push_back(wcm(N(4'd4, 1'b0), 5'd7, 32'h33, 4'd3));
        tbl.push_back(N(4'd4, 1'b0));
        // Fill, drop when full, wrap of the tag
        tbl.push_back(wr(I(OP_R_TYPE, 5'd1, 32'h0, 4'd1, 1'b0)));
        for (int i = 1; i < 8; i++) tbl.push_back(I(OP_R_TYPE, 5'(i + 1), 32'h0, 4'(i + 1), 1'b0));
        tbl.push_back(wc(I(OP_R_TYPE, 5'd9, 32'h0, 4'd1, 1'b1), 4'd1, 32'hA1, 32'h0));
        tbl.push_back(wcm(N(4'd1, 1'b1), 5'd1, 32'hA1, 4'd1));
        tbl.push_back(I(OP_R_TYPE, 5'd10, 32'h0, 4'd1, 1'b0));
        tbl.push_back(wq2(wq1(wc(N(4'd2, 1'b1), 4'd4, 32'hDEAD, 32'h0), 4'd4, 1'b1, 32'hDEAD), 4'd0, 1'b1, 32'h0));
        tbl.push_back(wq2(wq1(N(4'd2, 1'b1), 4'd1, 1'b0, 32'h0), 4'd4, 1'b1, 32'hDEAD));
        // Branch mispredict with younger entries and a same-cycle issue
        tbl.push_back(wr(I(OP_BRANCH, 5'd3, 32'h104, 4'd1, 1'b0)));
        tbl.push_back(I(OP_R_TYPE, 5'd8, 32'h0, 4'd2, 1'b0));
        tbl.push_back(I(OP_R_TYPE, 5'd9, 32'h0, 4'd3, 1'b0));
        tbl.push_back(wc(N(4'd4, 1'b0), 4'd1, 32'h200, 32'h0));
        tbl.push_back(wfl(wcm(I(OP_R_TYPE, 5'd4, 32'h0, 4'd4, 1'b0), 5'd0, 32'h200, 4'd1), 32'h200));
        tbl.push_back(N(4'd1, 1'b0));
        tbl.push_back(wc(N(4'd1, 1'b0), 4'd2, 32'h55, 32'h0));
        // Correctly predicted JALR commits its link value
        tbl.push_back(wq1(I(OP_JALR, 5'd1, 32'h300, 4'd1, 1'b0), 4'd2, 1'b0, 32'h0));
        tbl.push_back(wq1(wc(N(4'd2, 1'b0), 4'd1, 32'h300, 32'h108), 4'd1, 1'b1, 32'h300));
        tbl.push_back(wcm(wq1(N(4'd2, 1'b0), 4'd1, 1'b1, 32'h108), 5'd1, 32'h108, 4'd1));
        tbl.push_back(N(4'd2, 1'b0));
    endtask

    task automatic run_table();
        vec_t v;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.rst) pulse_reset();
            drive(v.rdy, v.iv, v.ity, v.ird, v.ipred, v.cv, v.ctag, v.cval, v.clink, v.q1, v.q2);
            #1;
            chk($sformatf("row%0d rob_full", i), rob_full, v.efull);
            chk($sformatf("row%0d new_tag", i), new_tag, v.entag);
            if (v.c1) begin
                chk($sformatf("row%0d ready1", i), ready1, v.er1);
                if (v.er1) chk($sformatf("row%0d res1", i), res1, v.eres1);
            end
            if (v.c2) begin
                chk($sformatf("row%0d ready2", i), ready2, v.er2);
                if (v.er2) chk($sformatf("row%0d res2", i), res2, v.eres2);
            end
            tick();
            chk($sformatf("row%0d commit_valid", i), commit_valid, v.ecv);
            chk($sformatf("row%0d flush", i), flush, v.efl);
            if (v.ecv) begin
                chk($sformatf("row%0d commit_rd", i), commit_rd, v.ecrd);
                chk($sformatf("row%0d commit_val", i), commit_val, v.ecval);
                chk($sformatf("row%0d commit_tag", i), commit_tag, v.ectag);
            end
            if (v.efl) chk($sformatf("row%0d flush_pc", i), flush_pc, v.eflpc);
        end
    endtask

    // ---------------- behavioural model for random traffic ----------------
    typedef struct {
        logic [5:0] ty; logic [4:0] rd; logic [31:0] pred, val, link; bit done;
    } ment_t;

    ment_t       mq[$];     // in-flight instructions, oldest first
    int          mhead;     // slot of mq[0]; tag = slot + 1
    logic        e_cv, e_fl;
    logic [4:0]  e_crd;
    logic [31:0] e_cval, e_flpc;
    logic [3:0]  e_ctag;

    function automatic int find(input int tag);
        int k;
        if (tag < 1 || tag > 8) return -1;
        k = (tag - 1 - mhead + 8) % 8;
        return (k < mq.size()) ? k : -1;
    endfunction

    function automatic logic [5:0] pick_op(input int n);
        case (n)
            0:       return OP_LUI;
            1:       return OP_AUIPC;
            2:       return OP_JAL;
            3:       return OP_JALR;
            4:       return OP_BRANCH;
            5:       return OP_I_TYPE;
            default: return OP_R_TYPE;
        endcase
    endfunction

    task automatic chk_lookup(input string name, input logic [3:0] q, input logic r, input logic [31:0] res);
        int k;
        if (q == 4'd0) begin
            chk({name, " ready zero-tag"}, r, 1'b1);
            chk({name, " res zero-tag"}, res, 32'h0);
        end else if (cdb_valid && cdb_tag == q) begin
            chk({name, " ready bypass"}, r, 1'b1);
            chk({name, " res bypass"}, res, cdb_val);
        end else begin
            k = find(int'(q));
            if (k >= 0) begin
                chk({name, " ready entry"}, r, mq[k].done);
                if (mq[k].done)
                    chk({name, " res entry"}, res,
                        (mq[k].ty == OP_JAL || mq[k].ty == OP_JALR) ? mq[k].link : mq[k].val);
            end
        end
    endtask

    task automatic run_random(input int cycles);
        logic        r_rdy, r_iv, r_cv, do_commit, do_mis, do_issue;
        logic [5:0]  r_ty;
        logic [4:0]  r_rd;
        logic [3:0]  r_ct, r_q1, r_q2;
        logic [31:0] r_pred, r_cval, r_clink;
        int          k, kc;
        ment_t       h, ne;
        pulse_reset();
        mq.delete(); mhead = 0;
        e_cv = 1'b0; e_fl = 1'b0; e_crd = 5'd0; e_cval = 32'h0; e_flpc = 32'h0; e_ctag = 4'd0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            r_rdy   = ($urandom_range(0, 9) != 0);
            r_iv    = ($urandom_range(0, 9) < 6);
            r_ty    = pick_op($urandom_range(0, 6));
            r_rd    = 5'($urandom);
            r_pred  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
            r_cv    = 1'($urandom_range(0, 1));
            r_ct    = 4'd0;
            r_cval  = $urandom;
            r_clink = $urandom;
            if (r_cv) begin
                if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
                    k = $urandom_range(0, mq.size() - 1);
                    r_ct = 4'(((mhead + k) % 8) + 1);
                    if ((mq[k].ty == OP_BRANCH || mq[k].ty == OP_JALR) && $urandom_range(0, 9) < 8)
                        r_cval = mq[k].pred;
                end else begin
                    r_ct = 4'($urandom_range(0, 15));
                end
            end
            r_q1 = 4'($urandom_range(0, 9));
            r_q2 = 4'($urandom_range(0, 9));
            drive(r_rdy, r_iv, r_ty, r_rd, r_pred, r_cv, r_ct, r_cval, r_clink, r_q1, r_q2);
            #1;
            chk("rnd rob_full", rob_full, mq.size() == 8);
            chk("rnd new_tag", new_tag, 32'(((mhead + mq.size()) % 8) + 1));
            chk_lookup("rnd q1", r_q1, ready1, res1);
            chk_lookup("rnd q2", r_q2, ready2, res2);

            // Model: decide from the state before the edge, then update.
            do_commit = r_rdy && mq.size() > 0 && mq[0].done;
            do_mis    = 1'b0;
            do_issue  = r_rdy && r_iv && (mq.size() < 8);
            if (do_commit) begin
                h      = mq[0];
                do_mis = (h.ty == OP_BRANCH || h.ty == OP_JALR) && (h.val != h.pred);
                e_crd  = (h.ty == OP_BRANCH) ? 5'd0 : h.rd;
                e_cval = (h.ty == OP_JAL || h.ty == OP_JALR) ? h.link : h.val;
                e_ctag = 4'(mhead + 1);
                if (do_mis) e_flpc = h.val;
            end
            e_cv = do_commit;
            e_fl = do_mis;
            kc = find(int'(r_ct));
            if (r_rdy && r_cv && kc >= 0) begin
                mq[kc].val = r_cval; mq[kc].link = r_clink; mq[kc].done = 1'b1;
            end
            if (do_commit) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % 8;
            end
            if (do_mis) begin
                mq.delete();
                mhead = 0;
            end else if (do_issue) begin
                ne.ty = r_ty; ne.rd = r_rd; ne.pred = r_pred; ne.val = 32'h0; ne.link = 32'h0; ne.done = 1'b0;
                mq.push_back(ne);
            end

            tick();
            chk("rnd commit_valid", commit_valid, e_cv);
            chk("rnd flush", flush, e_fl);
            chk("rnd commit_rd", commit_rd, e_crd);
            chk("rnd commit_val", commit_val, e_cval);
            chk("rnd commit_tag", commit_tag, e_ctag);
            chk("rnd flush_pc", flush_pc, e_flpc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1;
        drive(1'b1, 1'b0, 6'd0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        #1;
        // Reset state
        chk("reset rob_full", rob_full, 1'b0);
        chk("reset new_tag", new_tag, 4'd1);
        chk("reset commit_valid", commit_valid, 1'b0);
        chk("reset commit_tag", commit_tag, 4'd0);
        chk("reset flush", flush, 1'b0);
        chk("reset flush_pc", flush_pc, 32'h0);
        tick();

        build_table();
        run_table();

        // Stall: head is ready but rdy_in is low for three cycles
        pulse_reset();
        drive(1'b1, 1'b1, OP_R_TYPE, 5'd12, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0);
        tick();
        drive(1'b1, 1'b0, OP_R_TYPE, 5'd0, 32'h0, 1'b1, 4'd1, 32'h77, 32'h0, 4'd0, 4'd0);
        tick();
        chk("stall pre commit_valid", commit_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, OP_R_TYPE, 5'd13, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0);
            #1;
            chk($sformatf("stall%0d new_tag", i), new_tag, 4'd2);
            tick();
            chk($sformatf("stall%0d commit_valid", i), commit_valid, 1'b0);
        end
        drive(1'b1, 1'b0, OP_R_TYPE, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0);
        tick();
        chk("stall commit_valid", commit_valid, 1'b1);
        chk("stall commit_rd", commit_rd, 5'd12);
        chk("stall commit_val", commit_val, 32'h77);
        chk("stall commit_tag", commit_tag, 4'd1);

        // Asynchronous reset while a commit pulse is on the outputs
        #2;
        rst_in = 1'b1;
        #1;
        chk("async-rst commit_valid", commit_valid, 1'b0);
        chk("async-rst commit_rd", commit_rd, 5'd0);
        chk("async-rst commit_val", commit_val, 32'h0);
        chk("async-rst commit_tag", commit_tag, 4'd0);
        chk("async-rst flush", flush, 1'b0);
        chk("async-rst new_tag", new_tag, 4'd1);
        rst_in = 1'b0;
        tick();

        run_random(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer sitting between decode/issue and the register file.
- Allocates a nonzero tag per issued instruction; that tag becomes the reservation station's newTag.
- Answers operand-readiness lookups for the reservation station and captures results from the CDB driven by the ALU.
- Commits results in program order to the register file and raises a flush on branch/jump misprediction.

Parameters:
- ROB_SIZE, 8, number of entries; must be a power of two.
- ID_WIDTH, 4, tag width; tag = entry index + 1, and tag 0 means "no dependency".
- VAL_WIDTH, 32, data width.
- ADDR_WIDTH, 32, PC width.
- OP_WIDTH, 6, opcode-class width.

Ports:
- clk  in  1  clock
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global enable; when low, all state is frozen
- issue_valid  in  1  allocate an entry this cycle
- issue_type  in  OP_WIDTH  instruction class
- issue_rd  in  5  destination register; 0 means no write
- issue_pred_pc  in  ADDR_WIDTH  predicted next PC
- rob_full  out  1  no free entry; combinational
- new_tag  out  ID_WIDTH  tag the next issue will receive; combinational
- query_tag1, query_tag2  in  ID_WIDTH  operand tags from the register file
- ready1, ready2  out  1  operand value is available; combinational
- res1, res2  out  VAL_WIDTH  operand values; combinational
- cdb_valid  in  1  result broadcast
- cdb_tag  in  ID_WIDTH  producing tag
- cdb_val  in  VAL_WIDTH  result; for branches and jumps this is the actual next PC
- cdb_link  in  VAL_WIDTH  link value for JAL/JALR
- commit_valid  out  1  registered commit pulse
- commit_rd  out  5  destination register of the committed entry
- commit_val  out  VAL_WIDTH  value to write
- commit_tag  out  ID_WIDTH  lets the register file clear its dependency only if the tag still matches
- flush  out  1  registered one-cycle mispredict pulse
- flush_pc  out  ADDR_WIDTH  redirect target

Behaviour:
- Reset (async):
  - head = tail = 0, count = 0, all busy/ready bits = 0.
  - commit_valid = 0, commit_rd = 0, commit_val = 0, commit_tag = 0.
  - flush = 0, flush_pc = 0.
- Per-entry state: busy, ready, type, rd, pred_pc, value, link.
- rob_full = (count == ROB_SIZE); new_tag = tail + 1.
- Issue: if issue_valid && !rob_full && rdy_in, write entry[tail] with busy=1, ready=0, then tail++ (wraps modulo ROB_SIZE). Issue while full is silently dropped.
- CDB capture: if cdb_valid and entry[cdb_tag-1] is busy, set value=cdb_val, link=cdb_link, ready=1. A CDB write to a non-busy entry is ignored.
- Lookup, per operand n:
  - query_tagn == 0: readyn=1, resn=0.
  - cdb_valid && cdb_tag == query_tagn: readyn=1, resn=cdb_val (same-cycle bypass).
  - Otherwise: readyn and resn come from the entry's ready bit and result.
  - The result for JAL/JALR is the link value; for all other types it is the value.
- Commit: at most one per cycle, when entry[head] is busy && ready (state registered before this edge). The CDB-to-commit minimum latency is therefore 1 cycle.
  - Clear busy, head++, and register commit_valid=1, commit_rd=rd, commit_tag=head+1.
  - commit_val = link for JAL/JALR, value for all other types.
  - For branch types, commit_rd = 0.
- Mispredict: a committing branch/JALR whose value != pred_pc:
  - Register flush=1 and flush_pc=value.
  - Clear every busy/ready bit; head=tail=count=0.
  - Any same-cycle issue is discarded.
  - commit_valid still pulses for the JALR link write.
- Count update: +1 on issue, −1 on commit. A simultaneous issue and commit leaves count unchanged. A full buffer accepts a new issue only in a later cycle; rob_full is evaluated before the commit.
- Outputs: commit_valid and flush are one-cycle pulses, cleared at the next enabled edge.
- rdy_in low: no issue, capture, or commit; commit_valid and flush are registered to 0 on that edge.
- Reset mid-operation discards all entries immediately; outputs go to their reset values asynchronously.

Decomposition:
- Shared package/header: VAL_WIDTH, ADDR_WIDTH, ID_WIDTH, OP_WIDTH, ROB_SIZE, and opcode classes (OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_I_TYPE, OP_R_TYPE), all identical to those the reservation station uses.
- One natural sub-module: rob_lookup, the combinational tag-to-operand read with CDB bypass, instantiated twice.

Test Plan:
- Issue 3 ADDs (rd=5,6,7) from reset → new_tag values 1, 2, 3; CDB tag 2 val 0x22 then tag 1 val 0x11 → commits in order: (rd5, 0x11, tag1) on the cycle after tag 1's CDB, then (rd6, 0x22, tag2) on the next cycle.
- Fill 8 entries → rob_full=1 and a 9th issue is dropped. Commit one → rob_full=0 and new_tag=1 (wrap); the next issue gets tag 1.
- query_tag1=4 with cdb_valid, cdb_tag=4, cdb_val=0xDEAD in the same cycle → ready1=1, res1=0xDEAD. query_tag2=0 → ready2=1, res2=0.
- Branch tag 1 with pred_pc=0x104, CDB val=0x200, younger tags 2–3 present → flush=1 and flush_pc=0x200 for exactly one cycle; afterwards count=0 and new_tag=1.
- JALR rd=1 with link=0x108, val=0x300, pred_pc=0x300 → commit_valid with rd1 and 0x108, no flush.
- rdy_in low for 3 cycles while the head is ready → no commit during the stall; the commit occurs on the first enabled edge. Asserting rst_in mid-stream → all outputs are 0 immediately.
